heap_sift_engine: RTL and testbench
===================================

HEAP_SIFT_ENGINE -- requirements
Module: heap_sift_engine

Interface
REQ-001 SHALL have parameter DW, default 32, signed element width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, heap storage capacity in elements (DEPTH >= 2).
REQ-003 SHALL have parameter MIN_HEAP, default 1: 1 = min-heap ordering, 0 = max-heap ordering.
REQ-004 SHALL have local constant AW = clog2(DEPTH+1), the index/size width.
REQ-005 SHALL have port system1000 (input, 1): the single clock; all state updates on its rising edge.
REQ-006 SHALL have port system1000_rstn (input, 1): asynchronous, active-low reset.
REQ-007 SHALL have port wr_en (input, 1): storage write strobe, honoured only when idle.
REQ-008 SHALL have port wr_addr (input, AW): storage write index.
REQ-009 SHALL have port wr_data (input, DW, signed): storage write value.
REQ-010 SHALL have port rd_addr (input, AW): combinational read index.
REQ-011 SHALL have port rd_data (output, DW, signed): mem[rd_addr], or 0 if rd_addr >= DEPTH.
REQ-012 SHALL have port start (input, 1): sift-down request, accepted only in IDLE.
REQ-013 SHALL have port root (input, AW): starting index of the sift.
REQ-014 SHALL have port size (input, AW): number of valid heap elements n.
REQ-015 SHALL have port busy (output, 1): high in every state except IDLE.
REQ-016 SHALL have port done (output, 1): one-cycle completion pulse.
REQ-017 SHALL have port swaps (output, AW, present only under HEAP_SIFT_CNT_EN): swaps performed in the last sift.

Function
REQ-018 SHALL implement the FSM states IDLE, CMP, SWAP and DONE.
REQ-019 IDLE with start=1: SHALL latch root into cur and min(size,DEPTH) into n; go to CMP if root < n, else go to DONE.
REQ-020 CMP: SHALL compute c1 = 2*cur+1 and c2 = 2*cur+2 in AW+2 bits, with no wrap-around.
REQ-021 CMP best-index rule: best = cur; if c1 < n and mem[c1] is strictly better than mem[best], best = c1; then if c2 < n and mem[c2] is strictly better than mem[best], best = c2.
REQ-022 "Strictly better" SHALL mean signed less-than when MIN_HEAP=1 and signed greater-than when MIN_HEAP=0; ties SHALL keep the earlier candidate.
REQ-023 CMP: SHALL register best into nxt; go to DONE if best == cur, else go to SWAP.
REQ-024 SWAP: SHALL exchange mem[cur] and mem[nxt] in one cycle, set cur <= nxt, and return to CMP.
REQ-025 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-026 Latency from the start-accept edge to done high SHALL be 2*k+2 cycles, where k is the number of swaps; root >= n gives 1 cycle.
REQ-027 start while busy SHALL be ignored; wr_en while busy SHALL be ignored, with no queueing.
REQ-028 In IDLE, wr_en with wr_addr >= DEPTH SHALL be dropped; simultaneous wr_en and start SHALL perform the write first, with the sift starting next cycle on the updated storage.
REQ-029 rd_data SHALL reflect storage contents combinationally in all states.

Reset
REQ-030 Asserting system1000_rstn low SHALL force the state to IDLE, with busy=0, done=0, cur=0, nxt=0, n=0, swaps=0 and all storage words 0.
REQ-031 Reset mid-sift SHALL abandon the operation immediately, with no done pulse.

Configuration
REQ-032 Macro HEAP_SIFT_CNT_EN SHALL control the swap counter.
REQ-033 With HEAP_SIFT_CNT_EN defined: a counter SHALL clear on start-accept, increment on each SWAP cycle, and hold after done until the next accept; port swaps SHALL be present.
REQ-034 Without HEAP_SIFT_CNT_EN: the counter and port swaps SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package heap_pkg SHALL hold the FSM state enum (IDLE/CMP/SWAP/DONE) and the better(a,b,min_heap) compare function.
REQ-036 Sub-module heap_swap_sel SHALL implement the combinational best-index selection of REQ-021/022.

Verification
REQ-037 Scenario min-heap sift, DEPTH=16, mem[0..6]={9,2,3,4,5,6,7}, start root=0 size=7 -> 2 swaps, mem[0..6]={2,4,3,9,5,6,7}, done exactly 6 cycles after accept, swaps=2.
REQ-038 Scenario tie, mem[0..2]={5,5,5}, root=0 size=3 -> 0 swaps, storage unchanged, done 2 cycles after accept.
REQ-039 Scenario MIN_HEAP=0, mem[0..2]={1,8,8}, root=0 size=3 -> swap with c1 only, mem={8,1,8}.
REQ-040 Scenario boundary, root=3 size=3 -> done 1 cycle after accept; size=20 with DEPTH=16 -> n clamped to 16, no out-of-range access.
REQ-041 Scenario interference, wr_en and start pulsed mid-sift -> both ignored, result identical to an undisturbed run.
REQ-042 Scenario reset, system1000_rstn asserted during SWAP -> busy=0 and rd_data=0 for all addresses, no done pulse.

Source files
------------

// File: rtl/heap_sift_engine_pkg.sv
// Shared definitions for the heap sift-down engine: FSM state encoding and
// the ordering predicate used to pick the winning element.
package heap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } heap_state_t;

    // Operands arrive sign-extended to 64 bits so one function serves any DW <= 64.
    function automatic logic better(input logic signed [63:0] a,
                                    input logic signed [63:0] b,
                                    input logic               min_heap);
        return min_heap ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/heap_sift_engine_if.sv
// Storage/control bundle of the heap sift engine.
// The swaps count is carried only when HEAP_SIFT_CNT_EN is defined.
interface heap_sift_engine_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] rd_data;
    logic                 start;
    logic [AW-1:0]        root;
    logic [AW-1:0]        size;
    logic                 busy;
    logic                 done;
`ifdef HEAP_SIFT_CNT_EN
    logic [AW-1:0]        swaps;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, start, root, size,
        input  rd_data, busy, done
`ifdef HEAP_SIFT_CNT_EN
        , input swaps
`endif
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, start, root, size,
        output rd_data, busy, done
`ifdef HEAP_SIFT_CNT_EN
        , output swaps
`endif
    );

endinterface

// File: rtl/heap_sift_engine_swap_sel.sv
// Combinational choice of the best of a node and its two children.
// Ties keep the earlier candidate, so equal keys never cause a swap.
module heap_swap_sel
    import heap_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MIN_HEAP = 1
) (
    input  logic [AW-1:0]        cur,
    input  logic [AW-1:0]        n,
    input  logic [AW+1:0]        c1,
    input  logic [AW+1:0]        c2,
    input  logic signed [DW-1:0] val_cur,
    input  logic signed [DW-1:0] val_c1,
    input  logic signed [DW-1:0] val_c2,
    output logic [AW-1:0]        best
);

    localparam logic MIN_SEL = (MIN_HEAP != 0);

    logic signed [DW-1:0] best_val;

    always_comb begin
        best     = cur;
        best_val = val_cur;
        // A child index below n is always below DEPTH, so its low AW bits are exact.
        if ((c1 < {2'b00, n}) && better(64'(val_c1), 64'(best_val), MIN_SEL)) begin
            best     = c1[AW-1:0];
            best_val = val_c1;
        end
        if ((c2 < {2'b00, n}) && better(64'(val_c2), 64'(best_val), MIN_SEL)) begin
            best     = c2[AW-1:0];
            best_val = val_c2;
        end
    end

endmodule

// File: rtl/heap_sift_engine.sv
// Heap sift-down engine: register-file storage plus a CMP/SWAP walk from a root.
// Optional swap counter on bus.swaps is built when HEAP_SIFT_CNT_EN is defined.
module heap_sift_engine
    import heap_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int MIN_HEAP = 1
) (
    input logic             system1000,
    input logic             system1000_rstn,
    heap_sift_engine_if.slave bus
);

    localparam int AW = $clog2(DEPTH + 1);

    heap_state_t          state_reg;
    logic [AW-1:0]        cur_reg;
    logic [AW-1:0]        nxt_reg;
    logic [AW-1:0]        n_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic signed [DW-1:0] mem [DEPTH];
`ifdef HEAP_SIFT_CNT_EN
    logic [AW-1:0]        swaps_reg;
`endif

    logic [AW-1:0]        n_clamp;
    logic [AW+1:0]        c1;
    logic [AW+1:0]        c2;
    logic signed [DW-1:0] val_cur;
    logic signed [DW-1:0] val_nxt;
    logic signed [DW-1:0] val_c1;
    logic signed [DW-1:0] val_c2;
    logic [AW-1:0]        best;
    logic                 wr_hit;
    logic                 swap_now;

    // Out-of-range indices read as zero instead of touching storage.
    function automatic logic signed [DW-1:0] rd_word(input logic [AW+1:0] idx);
        logic signed [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == (AW+2)'(i)) w = mem[i];
        end
        return w;
    endfunction

    assign n_clamp  = (bus.size > AW'(DEPTH)) ? AW'(DEPTH) : bus.size;
    assign c1       = {1'b0, cur_reg, 1'b1};
    assign c2       = {1'b0, cur_reg, 1'b0} + (AW+2)'(2);
    assign val_cur  = rd_word({2'b00, cur_reg});
    assign val_nxt  = rd_word({2'b00, nxt_reg});
    assign val_c1   = rd_word(c1);
    assign val_c2   = rd_word(c2);
    assign wr_hit   = (state_reg == IDLE) && bus.wr_en;
    assign swap_now = (state_reg == SWAP);

    heap_swap_sel #(
        .DW       (DW),
        .AW       (AW),
        .MIN_HEAP (MIN_HEAP)
    ) u_swap_sel (
        .cur     (cur_reg),
        .n       (n_reg),
        .c1      (c1),
        .c2      (c2),
        .val_cur (val_cur),
        .val_c1  (val_c1),
        .val_c2  (val_c2),
        .best    (best)
    );

    // Host writes land only in IDLE; a write beside start is visible to the first CMP.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit && (bus.wr_addr == AW'(i))) begin
                    mem[i] <= bus.wr_data;
                end else if (swap_now && (cur_reg == AW'(i))) begin
                    mem[i] <= val_nxt;
                end else if (swap_now && (nxt_reg == AW'(i))) begin
                    mem[i] <= val_cur;
                end
            end
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            nxt_reg   <= '0;
            n_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef HEAP_SIFT_CNT_EN
            swaps_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        cur_reg  <= bus.root;
                        n_reg    <= n_clamp;
                        busy_reg <= 1'b1;
`ifdef HEAP_SIFT_CNT_EN
                        swaps_reg <= '0;
`endif
                        if (bus.root < n_clamp) begin
                            state_reg <= CMP;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    nxt_reg <= best;
                    if (best == cur_reg) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= SWAP;
                    end
                end
                SWAP: begin
                    cur_reg   <= nxt_reg;
                    state_reg <= CMP;
`ifdef HEAP_SIFT_CNT_EN
                    swaps_reg <= swaps_reg + AW'(1);
`endif
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data = rd_word({2'b00, bus.rd_addr});
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
`ifdef HEAP_SIFT_CNT_EN
    assign bus.swaps   = swaps_reg;
`endif

endmodule

// File: tb/tb_heap_sift_engine.sv
// Bench for heap_sift_engine: a min-heap and a max-heap instance share one stimulus
// stream and are checked against an array-based sift-down model (HEAP_SIFT_CNT_EN aware).
module tb_heap_sift_engine;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #20 clk = ~clk;

    logic                 wr_en_v   = 1'b0;
    logic [AW-1:0]        wr_addr_v = '0;
    logic signed [DW-1:0] wr_data_v = '0;
    logic [AW-1:0]        rd_addr_v = '0;
    logic                 start_v   = 1'b0;
    logic [AW-1:0]        root_v    = '0;
    logic [AW-1:0]        size_v    = '0;

    heap_sift_engine_if #(.DW(DW), .AW(AW)) if_max ();
    heap_sift_engine_if #(.DW(DW), .AW(AW)) if_min ();

    assign if_min.wr_en   = wr_en_v;
    assign if_min.wr_addr = wr_addr_v;
    assign if_min.wr_data = wr_data_v;
    assign if_min.rd_addr = rd_addr_v;
    assign if_min.start   = start_v;
    assign if_min.root    = root_v;
    assign if_min.size    = size_v;
    assign if_max.wr_en   = wr_en_v;
    assign if_max.wr_addr = wr_addr_v;
    assign if_max.wr_data = wr_data_v;
    assign if_max.rd_addr = rd_addr_v;
    assign if_max.start   = start_v;
    assign if_max.root    = root_v;
    assign if_max.size    = size_v;

    heap_sift_engine #(.DW(DW), .DEPTH(DEPTH), .MIN_HEAP(1)) u_min (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (if_min)
    );

    heap_sift_engine #(.DW(DW), .DEPTH(DEPTH), .MIN_HEAP(0)) u_max (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (if_max)
    );

    // model[1] is the min-heap image, model[0] the max-heap image
    int model [2][DEPTH];
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit ref_better(input bit min_h, input int a, input int b);
        return min_h ? (a < b) : (a > b);
    endfunction

    // Textbook sift-down on the model array; returns the number of exchanges.
    function automatic int sift_model(input int m, input int root, input int n);
        int cur, l, r, best, tmp, k;
        k   = 0;
        cur = root;
        while (cur < n) begin
            l    = 2 * cur + 1;
            r    = 2 * cur + 2;
            best = cur;
            if (l < n && ref_better(m == 1, model[m][l], model[m][best])) best = l;
            if (r < n && ref_better(m == 1, model[m][r], model[m][best])) best = r;
            if (best == cur) break;
            tmp            = model[m][cur];
            model[m][cur]  = model[m][best];
            model[m][best] = tmp;
            cur            = best;
            k++;
        end
        return k;
    endfunction

    task automatic write_word(input int a, input int d);
        @(negedge clk);
        wr_en_v   = 1'b1;
        wr_addr_v = AW'(a);
        wr_data_v = d;
        @(negedge clk);
        wr_en_v = 1'b0;
        if (a < DEPTH) begin
            model[0][a] = d;
            model[1][a] = d;
        end
    endtask

    task automatic check_mem(input string tag);
        int e;
        @(negedge clk);
        for (int a = 0; a <= DEPTH; a++) begin
            rd_addr_v = AW'(a);
            #1;
            e = (a < DEPTH) ? model[1][a] : 0;
            check($sformatf("%s_min_mem%0d", tag, a), if_min.rd_data, e);
            e = (a < DEPTH) ? model[0][a] : 0;
            check($sformatf("%s_max_mem%0d", tag, a), if_max.rd_data, e);
        end
    endtask

    task automatic run_sift(input int root, input int size, input bit with_wr,
                            input int wa, input int wd, input bit disturb,
                            input string tag);
        int n, lat_max;
        int k [2];
        int lat_exp [2];
        int lat_got [2];
        int pulses [2];
        n = (size > DEPTH) ? DEPTH : size;
        if (with_wr && wa < DEPTH) begin
            model[0][wa] = wd;
            model[1][wa] = wd;
        end
        for (int m = 0; m < 2; m++) begin
            k[m]       = sift_model(m, root, n);
            lat_exp[m] = (root >= n) ? 1 : 2 * k[m] + 2;
            lat_got[m] = 0;
            pulses[m]  = 0;
        end
        lat_max = (lat_exp[0] > lat_exp[1]) ? lat_exp[0] : lat_exp[1];

        @(negedge clk);
        start_v   = 1'b1;
        root_v    = AW'(root);
        size_v    = AW'(size);
        wr_en_v   = with_wr;
        wr_addr_v = AW'(wa);
        wr_data_v = wd;
        @(negedge clk);
        for (int cnt = 1; cnt <= lat_max + 2; cnt++) begin
            if (cnt > 1) @(negedge clk);
            if (cnt == 1) begin
                start_v = 1'b0;
                wr_en_v = 1'b0;
                check({tag, "_min_busy"}, if_min.busy, 1);
                check({tag, "_max_busy"}, if_max.busy, 1);
            end
            if (if_min.done === 1'b1) begin
                pulses[1]++;
                if (lat_got[1] == 0) lat_got[1] = cnt;
            end
            if (if_max.done === 1'b1) begin
                pulses[0]++;
                if (lat_got[0] == 0) lat_got[0] = cnt;
            end
            if (disturb && cnt == 3) begin
                start_v   = 1'b1;
                root_v    = '0;
                size_v    = AW'(7);
                wr_en_v   = 1'b1;
                wr_addr_v = '0;
                wr_data_v = 99;
            end
            if (disturb && cnt == 4) begin
                start_v = 1'b0;
                wr_en_v = 1'b0;
            end
        end
        check({tag, "_min_lat"}, lat_got[1], lat_exp[1]);
        check({tag, "_max_lat"}, lat_got[0], lat_exp[0]);
        check({tag, "_min_pulses"}, pulses[1], 1);
        check({tag, "_max_pulses"}, pulses[0], 1);
        check({tag, "_min_idle"}, if_min.busy, 0);
        check({tag, "_max_idle"}, if_max.busy, 0);
`ifdef HEAP_SIFT_CNT_EN
        check({tag, "_min_swaps"}, if_min.swaps, k[1]);
        check({tag, "_max_swaps"}, if_max.swaps, k[0]);
`endif
        $display("sift %s root=%0d size=%0d min:k=%0d lat=%0d max:k=%0d lat=%0d",
                 tag, root, size, k[1], lat_got[1], k[0], lat_got[0]);
        check_mem(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v037 [7];
        int vdeep [7];
        int cnt_done;
        v037  = '{9, 2, 3, 4, 5, 6, 7};
        vdeep = '{5, 1, 9, 0, 3, 10, 4};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_min_busy", if_min.busy, 0);
        check("rst_max_busy", if_max.busy, 0);
        check("rst_min_done", if_min.done, 0);
        check("rst_max_done", if_max.done, 0);
`ifdef HEAP_SIFT_CNT_EN
        check("rst_min_swaps", if_min.swaps, 0);
`endif
        check_mem("rst");
        @(negedge clk);
        rstn = 1'b1;

        // documented min-heap example: two exchanges, done after six cycles
        for (int i = 0; i < 7; i++) write_word(i, v037[i]);
        run_sift(0, 7, 1'b0, 0, 0, 1'b0, "ex2swap");
        check("ex2swap_root", model[1][0], 2);
        check("ex2swap_leaf", model[1][3], 9);

        // equal keys never swap
        for (int i = 0; i < 3; i++) write_word(i, 5);
        run_sift(0, 3, 1'b0, 0, 0, 1'b0, "tie");

        // max-heap with equal children picks the left one
        write_word(0, 1);
        write_word(1, 8);
        write_word(2, 8);
        run_sift(0, 3, 1'b0, 0, 0, 1'b0, "maxtie");

        // root at or past n completes immediately
        run_sift(3, 3, 1'b0, 0, 0, 1'b0, "rootoob");

        // writes past DEPTH are dropped
        write_word(16, 77);
        write_word(31, -55);
        check_mem("wroob");

        // size beyond DEPTH is clamped
        for (int i = 0; i < DEPTH; i++) write_word(i, DEPTH - i);
        run_sift(0, 20, 1'b0, 0, 0, 1'b0, "clamp");

        // write alongside start lands before the sift begins
        run_sift(0, 3, 1'b1, 0, 100, 1'b0, "wrstart");

        // start and write pulsed mid-sift are ignored
        for (int i = 0; i < 7; i++) write_word(i, vdeep[i]);
        run_sift(0, 7, 1'b0, 0, 0, 1'b1, "disturb");

        // randomized trees
        for (int it = 0; it < 15; it++) begin
            for (int j = 0; j < 6; j++)
                write_word(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)) - 8);
            run_sift(int'($urandom_range(0, 6)), int'($urandom_range(0, 20)),
                     1'b1, int'($urandom_range(0, 18)), int'($urandom_range(0, 31)) - 16,
                     1'b0, $sformatf("rand%0d", it));
        end

        // reset while both engines sit in SWAP
        for (int i = 0; i < 7; i++) write_word(i, vdeep[i]);
        @(negedge clk);
        start_v = 1'b1;
        root_v  = '0;
        size_v  = AW'(7);
        @(negedge clk);
        start_v = 1'b0;
        @(negedge clk);
        check("midrst_min_busy_pre", if_min.busy, 1);
        check("midrst_max_busy_pre", if_max.busy, 1);
        rstn = 1'b0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DEPTH; i++) model[m][i] = 0;
        #1;
        check("midrst_min_busy", if_min.busy, 0);
        check("midrst_max_busy", if_max.busy, 0);
        for (int a = 0; a <= DEPTH; a++) begin
            rd_addr_v = AW'(a);
            #1;
            check($sformatf("midrst_min_rd%0d", a), if_min.rd_data, 0);
            check($sformatf("midrst_max_rd%0d", a), if_max.rd_data, 0);
        end
        cnt_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (if_min.done === 1'b1 || if_max.done === 1'b1) cnt_done++;
        end
        rstn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (if_min.done === 1'b1 || if_max.done === 1'b1 ||
                if_min.busy === 1'b1 || if_max.busy === 1'b1) cnt_done++;
        end
        check("midrst_no_done", cnt_done, 0);
        $display("reset mid-swap abandoned sift");
        check_mem("postrst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
